halton3_seq_ctrl: RTL
=====================

// Module: halton3_seq_ctrl
// PURPOSE
//  Sequencer for a base-3 Halton (radical-inverse) generator built from a chain
//  of DIGITS mod-3 digit counters. Accepts a run command (start + sample count),
//  steps the digit chain once per accepted output, and streams the digit-reversed
//  value over a valid/ready interface. Sits between the stochastic-number
//  generator consumers and the base-3 digit counters.
// PARAMETERS
//  DIGITS  3   number of base-3 digits; sequence period = 3**DIGITS
//  LEN_W   8   width of run-length command
//  OUT_W   5   output value width; must satisfy 2**OUT_W >= 3**DIGITS
//  CONT    0   0: index cleared on each start; 1: index continues from last run
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-high reset
//  start      in   1          run request; sampled only in IDLE
//  len        in   LEN_W      samples to emit; captured when start accepted
//  abort      in   1          terminate current run
//  out_ready  in   1          consumer ready
//  out_valid  out  1          output sample valid
//  out_val    out  OUT_W      radical-inverse value, sum d[i]*3**(DIGITS-1-i)
//  out_digits out  2*DIGITS   reversed digit vector, 2 bits/digit, MSD = d[0]
//  busy       out  1          high in RUN
//  done       out  1          one-cycle pulse when run completes or aborts
//  wrap       out  1          one-cycle pulse on index roll-over 3**DIGITS-1 -> 0
// BEHAVIOUR
//  - Reset: FSM=IDLE, all digits 0, remaining count 0; out_valid, busy, done,
//    wrap = 0; out_val = 0, out_digits = 0.
//  - Digits d[i] in {0,1,2}; encoding 2'b11 never occurs. d[0] incremented on
//    every accepted transfer (out_valid & out_ready); d[i] carries into d[i+1]
//    when d[i]==2 and incremented (ripple in one cycle, 2->0 with carry out).
//  - FSM IDLE: start=1 -> capture len; CONT=0 clears digits. len!=0 -> RUN;
//    len==0 -> DONE (no samples). start ignored outside IDLE.
//  - RUN: out_valid=1 combinationally from state; out_val/out_digits reflect
//    current digits (registered state, zero extra latency). Value holds stable
//    while out_valid & !out_ready. On transfer: step digits, decrement count;
//    last transfer (count==1) -> DONE next cycle; out_valid drops same edge.
//  - First sample after a CONT=0 start is index 0 -> out_val 0; first valid
//    appears the cycle after start is sampled.
//  - wrap pulses the cycle after the transfer that stepped all-2 digits to 0.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy=0.
//  - abort in RUN: -> DONE next edge regardless of out_ready; a transfer in the
//    same cycle still completes and steps digits. abort in IDLE/DONE ignored.
//    abort has priority over normal last-sample completion (single done pulse).
//  - Async rst mid-run: immediate return to reset values; no done pulse.
//  - out_val width: OUT_W; upper bits beyond 3**DIGITS-1 always 0.
// TESTING
//  - Reset: assert rst mid-RUN -> out_valid/busy/done drop asynchronously, digits 0.
//  - DIGITS=3, start len=6, ready=1 -> out_val 0,9,18,3,12,21, done one cycle after.
//  - len=30, ready=1 -> out_val at index 26 is 26, index 27 is 0, wrap pulse once.
//  - Backpressure: ready toggled randomly -> each value held until accepted,
//    no skipped/duplicated index; total transfers == len.
//  - abort after 2 transfers of len=10 -> done pulse, busy 0; CONT=1 restart
//    len=2 -> out_val 18,3.
//  - start with len=0 -> done pulse after 1 cycle, out_valid never asserted.

Source files
------------

// File: rtl/halton3_seq_ctrl.sv
// halton3_seq_ctrl
//   Run sequencer for a base-3 Halton (radical-inverse) generator. A chain of
//   DIGITS mod-3 counters holds the sample index (d[0] least significant). One
//   start command emits len samples over a valid/ready stream. The value on
//   the stream is the digit-reversed index, sum d[i]*3**(DIGITS-1-i).
//
//   Handshake: out_valid is a pure function of state (high in RUN). A transfer
//   happens on a rising edge where out_valid & out_ready. out_val and
//   out_digits stay stable while out_valid & !out_ready.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        run request, sampled only in IDLE
//   len          samples to emit, captured with start
//   abort        ends the current run (RUN only)
//   out_ready    consumer ready
//   out_valid    sample valid (RUN)
//   out_val      radical-inverse value
//   out_digits   reversed digits, 2 bits each, MSB pair = d[0]
//   busy         high in RUN
//   done         one-cycle pulse when a run completes or aborts
//   wrap         one-cycle pulse after the index rolls over to 0
//   dbg_state_o  current FSM state, for observation

module halton3_seq_ctrl #(
    parameter int DIGITS = 3,
    parameter int LEN_W  = 8,
    parameter int OUT_W  = 5,
    parameter bit CONT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic                  abort,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_val,
    output logic [2*DIGITS-1:0]   out_digits,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DIGITS-1:0][1:0]  dig_q, dig_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    wrap_q, wrap_d;

    logic [DIGITS-1:0][1:0]  dig_inc;
    logic                    all_two;
    logic                    xfer;

    assign xfer = (state_q == S_RUN) && out_ready;

    // Ripple increment of the digit chain; a carry that survives the last
    // digit means every digit was 2, i.e. the index is rolling over.
    always_comb begin : step_digits
        logic carry;
        dig_inc = dig_q;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (dig_q[i] == 2'd2) begin
                    dig_inc[i] = 2'd0;
                end else begin
                    dig_inc[i] = dig_q[i] + 2'd1;
                    carry      = 1'b0;
                end
            end
        end
        all_two = carry;
    end

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = len;
                    if (!CONT) begin
                        dig_d = '0;
                    end
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    dig_d  = dig_inc;
                    cnt_d  = cnt_q - LEN_W'(1);
                    wrap_d = all_two;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                // Abort and last-sample completion both land in DONE, so a
                // coincident pair still yields a single done pulse.
                if (abort) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dig_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    // Horner evaluation with d[0] as the most significant base-3 digit.
    always_comb begin
        out_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            out_val = OUT_W'(out_val * 3) + OUT_W'(dig_q[i]);
        end
    end

    always_comb begin
        out_digits = '0;
        for (int i = 0; i < DIGITS; i++) begin
            out_digits[2*(DIGITS-1-i) +: 2] = dig_q[i];
        end
    end

    assign out_valid   = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign wrap        = wrap_q;
    assign dbg_state_o = state_q;

endmodule
